// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM state encoding for the SPI RAM responder.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA_RD,
    DATA_WR,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_ram_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus one-clock rise/fall pulses
// derived from the synchronized history.
module spi_ram_sync_edge #(
  parameter int   SYNC_STG = 2,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STG-1:0] sync_q;
  logic                prev;

  // Reset to the pin's idle level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STG{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      prev   <= sync_q[SYNC_STG-1];
    end
  end

  assign level = sync_q[SYNC_STG-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM target: READ 0x03 / WRITE 0x02 with an 8-bit address, host preload port.
// Optional SPI_RAM_WEL_EN adds WREN 0x06 / RDSR 0x05 and gates writes on the WEL flag.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int  MEM_BYTES = 256,
  parameter int  SYNC_STG  = 2,
  localparam int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_ram_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_ram_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .din(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_ram_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_pins;
  assign unused_pins = ^{sck_lvl, mosi_rise, mosi_fall};

  logic [7:0]        mem [MEM_BYTES];
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [2:0]        tx_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [ADDR_W-1:0] addr;
  logic              op_write;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] rx_addr;
  logic              byte_done;
  logic              wel_ok;
  logic              spi_we;
  logic [7:0]        reload_byte;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign rx_byte   = {rx_shift[6:0], mosi_lvl};
  assign rx_addr   = ADDR_W'(rx_byte);
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE);
  assign busy      = ~cs_lvl;

`ifdef SPI_RAM_WEL_EN
  logic wel;
  logic rdsr_mode;
  assign wel_ok      = wel;
  assign reload_byte = rdsr_mode ? {6'b0, wel, 1'b0} : mem[addr_inc(addr)];
`else
  assign wel_ok      = 1'b1;
  assign reload_byte = mem[addr_inc(addr)];
`endif

  assign spi_we = (state == DATA_WR) && byte_done && !cs_rise && !rst && wel_ok;

  // Host port has priority when both sides target the same byte in one clock.
  always_ff @(posedge clk) begin
    if (host_we) mem[host_addr] <= host_wdata;
    if (spi_we && !(host_we && (host_addr == addr))) mem[addr] <= rx_byte;
  end

  assign host_rdata = mem[host_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      tx_cnt   <= 3'd0;
      rx_shift <= 8'd0;
      tx_shift <= 8'd0;
      addr     <= '0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      op_write <= 1'b0;
`ifdef SPI_RAM_WEL_EN
      wel       <= 1'b0;
      rdsr_mode <= 1'b0;
`endif
    end else if (cs_rise) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      tx_cnt   <= 3'd0;
      rx_shift <= 8'd0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      op_write <= 1'b0;
`ifdef SPI_RAM_WEL_EN
      rdsr_mode <= 1'b0;
      if (op_write) wel <= 1'b0;
`endif
    end else begin
      if (sck_rise && (state != IDLE)) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'd0;
          end
        end
        CMD: begin
          if (byte_done) begin
            case (rx_byte)
              CMD_READ:  state <= ADDR;
              CMD_WRITE: begin
                state    <= ADDR;
                op_write <= 1'b1;
              end
`ifdef SPI_RAM_WEL_EN
              CMD_WREN: begin
                wel   <= 1'b1;
                state <= IGNORE;
              end
              CMD_RDSR: begin
                state     <= DATA_RD;
                rdsr_mode <= 1'b1;
                tx_shift  <= {6'b0, wel, 1'b0};
                tx_cnt    <= 3'd0;
                miso_oe   <= 1'b1;
              end
`endif
              default:   state <= IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (byte_done) begin
            addr <= rx_addr;
            if (op_write) begin
              state <= DATA_WR;
            end else begin
              state    <= DATA_RD;
              tx_shift <= mem[rx_addr];
              tx_cnt   <= 3'd0;
              miso_oe  <= 1'b1;
            end
          end
        end
        DATA_RD: begin
          // Each fall presents the current MSB; the eighth fall also prefetches the next byte.
          if (sck_fall) begin
            miso <= tx_shift[7];
            if (tx_cnt == 3'd7) begin
              tx_cnt   <= 3'd0;
              addr     <= addr_inc(addr);
              tx_shift <= reload_byte;
            end else begin
              tx_cnt   <= tx_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        DATA_WR: begin
          if (byte_done) addr <= addr_inc(addr);
        end
        IGNORE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder: bit-level SPI master, byte-array memory model.
module tb_spi_ram_responder;
  import spi_ram_pkg::*;

  localparam int SYNC_STG = 2;
  localparam int HALF     = 8;

  logic       clk = 1'b0;
  logic       rst, cs_n, sck, mosi, miso, miso_oe, busy, host_we;
  logic [7:0] host_addr, host_wdata, host_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [256];
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] spi_rx;
  logic       spi_oe_all, spi_oe_any;
  logic       hdr_oe, data_oe;

  always #5 clk = ~clk;

  spi_ram_responder #(.MEM_BYTES(256), .SYNC_STG(SYNC_STG)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .busy(busy), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits);
    spi_rx = 8'd0; spi_oe_all = 1'b1; spi_oe_any = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      tick(HALF);
      sck = 1'b1;
      spi_rx = {spi_rx[6:0], miso};
      spi_oe_all &= miso_oe;
      spi_oe_any |= miso_oe;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_stop();
    tick(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic spi_read(input logic [7:0] op, input logic [7:0] a, input int n, input bit send_addr);
    rd_q.delete();
    hdr_oe = 1'b0; data_oe = 1'b1;
    cs_start();
    spi_bits(op, 8);
    hdr_oe |= spi_oe_any;
    if (send_addr) begin
      spi_bits(a, 8);
      hdr_oe |= spi_oe_any;
    end
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8);
      rd_q.push_back(spi_rx);
      data_oe &= spi_oe_all;
    end
    cs_stop();
  endtask

  task automatic spi_write(input logic [7:0] op, input logic [7:0] a);
    hdr_oe = 1'b0;
    cs_start();
    spi_bits(op, 8);
    hdr_oe |= spi_oe_any;
    spi_bits(a, 8);
    hdr_oe |= spi_oe_any;
    foreach (wr_q[k]) begin
      spi_bits(wr_q[k], 8);
      hdr_oe |= spi_oe_any;
    end
    cs_stop();
  endtask

  task automatic send_wren();
    cs_start();
    spi_bits(CMD_WREN, 8);
    cs_stop();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    host_we = 1'b0; host_addr = 8'd0; host_wdata = 8'd0;
    tick(4);
    rst = 1'b0;
    tick(1);
    total++;
    if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    total++;
    if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_read_stream();
    logic [7:0] e, g;
    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom));
    spi_read(CMD_READ, 8'h00, 16, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(model_mem[i]);
    total++;
    if (rd_q.size() != 16) begin bad++; $display("FAIL read_stream_len got=%0d exp=16", rd_q.size()); end
    for (int i = 0; i < 16 && rd_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = rd_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL read_stream[%0d] got=%h exp=%h", i, g, e); end
    end
    exp_q.delete();
    total++;
    if (hdr_oe !== 1'b0) begin bad++; $display("FAIL read_hdr_oe got=%b exp=0", hdr_oe); end
    total++;
    if (data_oe !== 1'b1) begin bad++; $display("FAIL read_data_oe got=%b exp=1", data_oe); end
    total++;
    if (miso_oe !== 1'b0) begin bad++; $display("FAIL read_end_oe got=%b exp=0", miso_oe); end
  endtask

  task automatic test_write_wrap();
    logic [7:0] a;
`ifdef SPI_RAM_WEL_EN
    send_wren();
`endif
    wr_q = '{8'hAA, 8'hBB, 8'hCC};
    spi_write(CMD_WRITE, 8'hFE);
    foreach (wr_q[k]) model_mem[8'(8'hFE + k)] = wr_q[k];
    for (int k = 0; k < 3; k++) begin
      a = 8'(8'hFE + k);
      host_addr = a; #1;
      total++;
      if (host_rdata !== model_mem[a]) begin
        bad++; $display("FAIL write_wrap[%h] got=%h exp=%h", a, host_rdata, model_mem[a]);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] a, old;
    a = 8'($urandom); old = model_mem[a];
`ifdef SPI_RAM_WEL_EN
    send_wren();
`endif
    cs_start();
    spi_bits(CMD_WRITE, 8);
    spi_bits(a, 8);
    spi_bits(~old, 5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_mid got=%b exp=1", busy); end
    cs_stop();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_end got=%b exp=0", busy); end
    host_addr = a; #1;
    total++;
    if (host_rdata !== old) begin bad++; $display("FAIL abort_target got=%h exp=%h", host_rdata, old); end
    spi_read(CMD_READ, a, 2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rd_q[k] !== model_mem[8'(a + k)]) begin
        bad++; $display("FAIL abort_reread[%0d] got=%h exp=%h", k, rd_q[k], model_mem[8'(a + k)]);
      end
    end
  endtask

  task automatic test_ignore();
    logic [7:0] op;
    int mism;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) op = 8'h9F;
      else begin
        do op = 8'($urandom);
`ifdef SPI_RAM_WEL_EN
        while (op == CMD_READ || op == CMD_WRITE || op == CMD_WREN || op == CMD_RDSR);
`else
        while (op == CMD_READ || op == CMD_WRITE);
`endif
      end
      wr_q = '{8'($urandom), 8'($urandom)};
      spi_write(op, 8'($urandom));
      total++;
      if (hdr_oe !== 1'b0) begin bad++; $display("FAIL ignore_oe op=%h got=%b exp=0", op, hdr_oe); end
    end
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      host_addr = 8'(i); #1;
      if (host_rdata !== model_mem[i]) mism++;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL ignore_mem_scan got=%0d bad bytes exp=0", mism); end
    op = 8'($urandom);
    spi_read(CMD_READ, op, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd_q[k] !== model_mem[8'(op + k)]) begin
        bad++; $display("FAIL ignore_reread[%0d] got=%h exp=%h", k, rd_q[k], model_mem[8'(op + k)]);
      end
    end
  endtask

  // Host strobe lands d clocks after the pin edge of the final data bit; the SPI byte
  // commits SYNC_STG clocks after that edge, and the later-or-equal writer must win.
  task automatic write_with_host(input int d, input logic [7:0] ha, input logic [7:0] sv,
                                 input logic [7:0] hv);
`ifdef SPI_RAM_WEL_EN
    send_wren();
`endif
    cs_start();
    spi_bits(CMD_WRITE, 8);
    spi_bits(8'h20, 8);
    spi_bits(sv, 7);
    mosi = sv[0];
    tick(HALF);
    sck = 1'b1;
    repeat (d) @(negedge clk);
    host_addr = ha; host_wdata = hv; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    tick(HALF - d - 1);
    sck = 1'b0;
    cs_stop();
  endtask

  task automatic test_collision();
    logic [7:0] sv, hv, e;
    for (int d = 0; d < 5; d++) begin
      sv = 8'($urandom); hv = ~sv;
      write_with_host(d, 8'h20, sv, hv);
      e = (d < SYNC_STG) ? sv : hv;
      model_mem[8'h20] = e;
      host_addr = 8'h20; #1;
      total++;
      if (host_rdata !== e) begin bad++; $display("FAIL collide_same d=%0d got=%h exp=%h", d, host_rdata, e); end
    end
    sv = 8'($urandom); hv = ~sv;
    write_with_host(SYNC_STG, 8'h21, sv, hv);
    model_mem[8'h20] = sv; model_mem[8'h21] = hv;
    host_addr = 8'h20; #1;
    total++;
    if (host_rdata !== sv) begin bad++; $display("FAIL collide_diff_spi got=%h exp=%h", host_rdata, sv); end
    host_addr = 8'h21; #1;
    total++;
    if (host_rdata !== hv) begin bad++; $display("FAIL collide_diff_host got=%h exp=%h", host_rdata, hv); end
  endtask

  task automatic test_random();
    logic [7:0] a, e, g;
    int n;
    for (int t = 0; t < 8; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        wr_q.delete();
        for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom));
`ifdef SPI_RAM_WEL_EN
        send_wren();
`endif
        spi_write(CMD_WRITE, a);
        foreach (wr_q[k]) model_mem[8'(a + k)] = wr_q[k];
      end else begin
        spi_read(CMD_READ, a, n, 1'b1);
        for (int k = 0; k < n; k++) exp_q.push_back(model_mem[8'(a + k)]);
        for (int k = 0; k < n; k++) begin
          e = exp_q.pop_front(); g = rd_q.pop_front();
          total++;
          if (g !== e) begin bad++; $display("FAIL random_read a=%h k=%0d got=%h exp=%h", a, k, g, e); end
        end
      end
    end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] a;
    int mism;
    a = 8'($urandom);
    cs_start();
    spi_bits(CMD_READ, 8);
    spi_bits(a, 8);
    spi_bits(8'h00, 8);
    total++;
    if (spi_rx !== model_mem[a]) begin bad++; $display("FAIL rst_read_byte got=%h exp=%h", spi_rx, model_mem[a]); end
    spi_bits(8'h00, 3);
    total++;
    if (miso_oe !== 1'b1) begin bad++; $display("FAIL rst_pre_oe got=%b exp=1", miso_oe); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (miso_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", miso_oe); end
    total++;
    if (miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b exp=0", miso); end
    cs_stop();
    mism = 0;
    for (int i = 0; i < 256; i++) begin
      host_addr = 8'(i); #1;
      if (host_rdata !== model_mem[i]) mism++;
    end
    total++;
    if (mism != 0) begin bad++; $display("FAIL rst_mem_scan got=%0d bad bytes exp=0", mism); end
  endtask

`ifdef SPI_RAM_WEL_EN
  task automatic test_wel();
    logic [7:0] old;
    old = model_mem[8'h10];
    wr_q = '{8'h55};
    spi_write(CMD_WRITE, 8'h10);
    host_addr = 8'h10; #1;
    total++;
    if (host_rdata !== old) begin bad++; $display("FAIL wel_nowren got=%h exp=%h", host_rdata, old); end
    send_wren();
    spi_read(CMD_RDSR, 8'h00, 2, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rd_q[k] !== 8'h02) begin bad++; $display("FAIL wel_rdsr_set[%0d] got=%h exp=02", k, rd_q[k]); end
    end
    spi_write(CMD_WRITE, 8'h10);
    model_mem[8'h10] = 8'h55;
    host_addr = 8'h10; #1;
    total++;
    if (host_rdata !== 8'h55) begin bad++; $display("FAIL wel_write got=%h exp=55", host_rdata); end
    spi_read(CMD_RDSR, 8'h00, 1, 1'b0);
    total++;
    if (rd_q[0] !== 8'h00) begin bad++; $display("FAIL wel_rdsr_clr got=%h exp=00", rd_q[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_stream();
    test_write_wrap();
    test_abort();
    test_ignore();
    test_collision();
    test_random();
    test_rst_mid_read();
`ifdef SPI_RAM_WEL_EN
    test_wel();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
